// File: rtl/lexer_char_to_token.sv
// Character-stream tokeniser producing {kind, value} tokens for the LR parser.
// Optional build macro LEXER_NUM_SAT_EN: number literals saturate at 8'hFF instead of wrapping.
module lexer_char_to_token #(
    parameter logic [7:0] TOK_NUM  = 8'h00,
    parameter logic [7:0] TOK_PLUS = 8'h01,
    parameter logic [7:0] TOK_STAR = 8'h02,
    parameter logic [7:0] TOK_EOF  = 8'h03,
    parameter logic [7:0] EOF_CHAR = 8'h3B
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        I_VALID,
    input  logic [7:0]  I_CHAR,
    output logic        O_READY,
    output logic        O_VALID,
    output logic [15:0] O_TOKEN,
    input  logic        I_RECEIVE,
    output logic        DONE,
    output logic        ERROR,
    output logic [7:0]  ERR_CHAR
);

    localparam logic [2:0] S_SCAN  = 3'd0;
    localparam logic [2:0] S_NUM   = 3'd1;
    localparam logic [2:0] S_EMIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_char_q, pend_char_d;
    logic        eof_q, eof_d;
    logic [15:0] tok_q, tok_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  err_char_q, err_char_d;
    logic        have_char_s;
    logic [7:0]  char_s;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= 8'h30) && (ch <= 8'h39);
    endfunction

    function automatic logic is_space(input logic [7:0] ch);
        return (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0A) || (ch == 8'h0D);
    endfunction

    // ASCII digits sit at 0x30-0x39, so the low nibble is the digit value.
    function automatic logic [7:0] acc_step(input logic [7:0] acc, input logic [7:0] ch);
`ifdef LEXER_NUM_SAT_EN
        logic [11:0] wide;
        wide = ({4'h0, acc} * 12'd10) + {8'h00, ch[3:0]};
        return (wide > 12'd255) ? 8'hFF : wide[7:0];
`else
        return (acc * 8'd10) + {4'h0, ch[3:0]};
`endif
    endfunction

    assign have_char_s = pend_q | (I_VALID & ready_q);
    assign char_s      = pend_q ? pend_char_q : I_CHAR;

    // Next-state and datapath decode for the scanner FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pend_d      = pend_q;
        pend_char_d = pend_char_q;
        eof_d       = eof_q;
        tok_d       = tok_q;
        valid_d     = valid_q;
        done_d      = done_q;
        error_d     = error_q;
        err_char_d  = err_char_q;
        case (state_q)
            S_SCAN: begin
                if (have_char_s) begin
                    pend_d = 1'b0;
                    if (is_space(char_s)) begin
                        state_d = S_SCAN;
                    end else if (is_digit(char_s)) begin
                        acc_d   = {4'h0, char_s[3:0]};
                        state_d = S_NUM;
                    end else if (char_s == 8'h2B) begin
                        tok_d   = {TOK_PLUS, 8'h00};
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                    end else if (char_s == 8'h2A) begin
                        tok_d   = {TOK_STAR, 8'h00};
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                    end else if (char_s == EOF_CHAR) begin
                        tok_d   = {TOK_EOF, 8'h00};
                        eof_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        err_char_d = char_s;
                        error_d    = 1'b1;
                        state_d    = S_ERROR;
                    end
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_NUM: begin
                if (have_char_s) begin
                    if (is_digit(char_s)) begin
                        acc_d = acc_step(acc_q, char_s);
                    end else begin
                        // Terminator is replayed from the pending register after the token.
                        tok_d       = {TOK_NUM, acc_q};
                        pend_d      = 1'b1;
                        pend_char_d = char_s;
                        valid_d     = 1'b1;
                        state_d     = S_EMIT;
                    end
                end else begin
                    state_d = S_NUM;
                end
            end
            S_EMIT: begin
                if (I_RECEIVE) begin
                    valid_d = 1'b0;
                    state_d = eof_q ? S_DONE : S_SCAN;
                    done_d  = eof_q;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            S_ERROR: begin
                valid_d = 1'b0;
                error_d = 1'b1;
            end
            default: begin
                state_d = S_SCAN;
                valid_d = 1'b0;
            end
        endcase
        ready_d = ((state_d == S_SCAN) || (state_d == S_NUM)) && !pend_d;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_SCAN;
            acc_q       <= 8'h00;
            pend_q      <= 1'b0;
            pend_char_q <= 8'h00;
            eof_q       <= 1'b0;
            tok_q       <= 16'h0000;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_char_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            pend_char_q <= pend_char_d;
            eof_q       <= eof_d;
            tok_q       <= tok_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_char_q  <= err_char_d;
        end
    end

    assign O_READY  = ready_q;
    assign O_VALID  = valid_q;
    assign O_TOKEN  = tok_q;
    assign DONE     = done_q;
    assign ERROR    = error_q;
    assign ERR_CHAR = err_char_q;

endmodule

// File: tb/tb_lexer_char_to_token.sv
// Self-checking bench for lexer_char_to_token: fixed vectors, corner sequences, random strings.
module tb_lexer_char_to_token;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        I_VALID = 1'b0;
    logic [7:0]  I_CHAR = 8'h00;
    logic        I_RECEIVE = 1'b0;
    logic        O_READY, O_VALID, DONE, ERROR;
    logic [15:0] O_TOKEN;
    logic [7:0]  ERR_CHAR;

    lexer_char_to_token dut (
        .CLK(CLK), .RST_N(RST_N), .I_VALID(I_VALID), .I_CHAR(I_CHAR),
        .O_READY(O_READY), .O_VALID(O_VALID), .O_TOKEN(O_TOKEN),
        .I_RECEIVE(I_RECEIVE), .DONE(DONE), .ERROR(ERROR), .ERR_CHAR(ERR_CHAR)
    );

    always #5 CLK = ~CLK;

`ifdef LEXER_NUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [15:0] T300 = SAT ? 16'h00FF : 16'h002C;

    typedef struct packed {
        logic [63:0] text;
        logic [63:0] toks;
        logic [2:0]  ntok;
        logic        done;
        logic        err;
        logic [7:0]  errc;
    } vec_t;

    vec_t vecs[9];
    int checks = 0;
    int errors = 0;
    byte unsigned src_q[$];
    logic [15:0]  exp_q[$];
    bit           exp_done, exp_err;
    logic [7:0]   exp_errc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic vec_t mk(input string s, input logic [63:0] toks, input logic [2:0] n,
                                input logic dn, input logic er, input logic [7:0] ec);
        vec_t v;
        v.text = 64'h0;
        for (int i = 0; i < s.len(); i++) v.text = {v.text[55:0], 8'(s[i])};
        v.toks = toks; v.ntok = n; v.done = dn; v.err = er; v.errc = ec;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        I_VALID = 1'b0; I_RECEIVE = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rst_valid", 16'(O_VALID), 16'h0);
        chk("rst_token", O_TOKEN, 16'h0);
        chk("rst_done", 16'(DONE), 16'h0);
        chk("rst_error", 16'(ERROR), 16'h0);
        chk("rst_errchar", 16'(ERR_CHAR), 16'h0);
        chk("rst_ready", 16'(O_READY), 16'h1);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Reference: walk the string as text, producing the token list and terminal status.
    task automatic build_model();
        int acc = 0;
        bit in_num = 1'b0;
        byte unsigned c;
        byte unsigned kept[$];
        exp_q.delete(); exp_done = 1'b0; exp_err = 1'b0; exp_errc = 8'h00;
        for (int i = 0; i < src_q.size(); i++) begin
            c = src_q[i];
            kept.push_back(c);
            if (in_num) begin
                if (c >= 8'h30 && c <= 8'h39) begin
                    acc = acc * 10 + (c - 8'h30);
                    if (SAT) begin if (acc > 255) acc = 255; end
                    else acc = acc % 256;
                    continue;
                end
                exp_q.push_back({8'h00, 8'(acc)});
                in_num = 1'b0;
            end
            if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D) continue;
            if (c >= 8'h30 && c <= 8'h39) begin acc = c - 8'h30; in_num = 1'b1; end
            else if (c == 8'h2B) exp_q.push_back(16'h0100);
            else if (c == 8'h2A) exp_q.push_back(16'h0200);
            else if (c == 8'h3B) begin exp_q.push_back(16'h0300); exp_done = 1'b1; break; end
            else begin exp_err = 1'b1; exp_errc = c; break; end
        end
        src_q = kept;
    endtask

    // Stream src_q in, consume tokens with rdelay-cycle latency (negative: random), check all.
    task automatic run(input int rdelay);
        int idx = 0, cnt = 0, cyc = 0;
        bit seen = 1'b0, acc_prev = 1'b0, rec_prev = 1'b0;
        while (1) begin
            @(negedge CLK);
            cyc++;
            if (acc_prev) begin idx++; I_VALID = 1'b0; end
            if (rec_prev) begin void'(exp_q.pop_front()); seen = 1'b0; end
            I_RECEIVE = 1'b0;
            if (exp_q.size() == 0 && ((exp_done && DONE) || (exp_err && ERROR))) break;
            if (cyc > 3000) begin flag_fail("timeout"); break; end
            if (O_VALID) begin
                if (exp_q.size() == 0) begin
                    flag_fail("extra_token");
                    I_RECEIVE = 1'b1;
                end else begin
                    chk("token", O_TOKEN, exp_q[0]);
                    if (!seen) begin
                        seen = 1'b1;
                        cnt = (rdelay < 0) ? int'($urandom_range(0, 4)) : rdelay;
                    end
                    if (cnt == 0) I_RECEIVE = 1'b1;
                    else cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                I_RECEIVE = 1'b1;
            end
            if (idx < src_q.size()) begin
                if (!I_VALID) I_VALID = ($urandom_range(0, 3) != 0);
                I_CHAR = src_q[idx];
            end else begin
                I_VALID = 1'b0;
            end
            acc_prev = I_VALID && O_READY;
            rec_prev = I_RECEIVE && O_VALID;
        end
        I_VALID = 1'b0;
        chk("end_done", 16'(DONE), 16'(exp_done));
        chk("end_error", 16'(ERROR), 16'(exp_err));
        chk("end_errchar", 16'(ERR_CHAR), 16'(exp_errc));
        chk("end_valid", 16'(O_VALID), 16'h0);
        chk("end_ready", 16'(O_READY), 16'h0);
    endtask

    task automatic load_vec(input vec_t v);
        byte unsigned b;
        src_q.delete(); exp_q.delete();
        for (int i = 7; i >= 0; i--) begin
            b = v.text[i*8 +: 8];
            if (b != 8'h00) src_q.push_back(b);
        end
        for (int i = 0; i < int'(v.ntok); i++) exp_q.push_back(v.toks[63 - 16*i -: 16]);
        exp_done = v.done; exp_err = v.err; exp_errc = v.errc;
    endtask

    initial begin
        byte unsigned ws[4];
        byte unsigned ill[4];
        int n, r;
        ws  = '{8'h20, 8'h09, 8'h0A, 8'h0D};
        ill = '{8'h23, 8'h40, 8'h61, 8'h2D};
        vecs[0] = mk("1+2;",   {16'h0001, 16'h0100, 16'h0002, 16'h0300}, 3'd4, 1'b1, 1'b0, 8'h00);
        vecs[1] = mk("12*3 ;", {16'h000C, 16'h0200, 16'h0003, 16'h0300}, 3'd4, 1'b1, 1'b0, 8'h00);
        vecs[2] = mk("300;",   {T300, 16'h0300, 32'h0},                  3'd2, 1'b1, 1'b0, 8'h00);
        vecs[3] = mk("7#",     {16'h0007, 48'h0},                        3'd1, 1'b0, 1'b1, 8'h23);
        vecs[4] = mk(" \t+*;", {16'h0100, 16'h0200, 16'h0300, 16'h0},    3'd3, 1'b1, 1'b0, 8'h00);
        vecs[5] = mk("@",      64'h0,                                    3'd0, 1'b0, 1'b1, 8'h40);
        vecs[6] = mk("255+0;", {16'h00FF, 16'h0100, 16'h0000, 16'h0300}, 3'd4, 1'b1, 1'b0, 8'h00);
        vecs[7] = mk("9\n\r;", {16'h0009, 16'h0300, 32'h0},              3'd2, 1'b1, 1'b0, 8'h00);
        vecs[8] = mk(";",      {16'h0300, 48'h0},                        3'd1, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            load_vec(vecs[i]);
            run(-1);
        end

        // Parser slow to receive: first token must hold for the whole wait.
        do_reset();
        load_vec(vecs[1]);
        run(5);

        // Receive pulses with no token pending are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            I_RECEIVE = 1'b1;
            @(negedge CLK);
            I_RECEIVE = 1'b0;
            chk("spurious_valid", 16'(O_VALID), 16'h0);
            chk("spurious_ready", 16'(O_READY), 16'h1);
        end
        load_vec(vecs[0]);
        run(-1);

        // Operator latency, then asynchronous reset while the token is held.
        do_reset();
        @(negedge CLK);
        I_VALID = 1'b1; I_CHAR = 8'h2B;
        @(negedge CLK);
        I_VALID = 1'b0;
        chk("op_latency_valid", 16'(O_VALID), 16'h1);
        chk("op_latency_token", O_TOKEN, 16'h0100);
        @(negedge CLK);
        @(negedge CLK);
        chk("op_held_token", O_TOKEN, 16'h0100);
        #2 RST_N = 1'b0;
        #1;
        chk("async_valid", 16'(O_VALID), 16'h0);
        chk("async_done", 16'(DONE), 16'h0);
        chk("async_error", 16'(ERROR), 16'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        src_q.delete();
        src_q.push_back(8'h35); src_q.push_back(8'h3B);
        exp_q.delete();
        exp_q.push_back(16'h0005); exp_q.push_back(16'h0300);
        exp_done = 1'b1; exp_err = 1'b0; exp_errc = 8'h00;
        run(-1);

        // Random strings against the text-level reference.
        for (int t = 0; t < 40; t++) begin
            do_reset();
            src_q.delete();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 50)      src_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
                else if (r < 65) src_q.push_back(8'h2B);
                else if (r < 78) src_q.push_back(8'h2A);
                else if (r < 96) src_q.push_back(ws[$urandom_range(0, 3)]);
                else             src_q.push_back(ill[$urandom_range(0, 3)]);
            end
            src_q.push_back(8'h3B);
            build_model();
            run(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
